// File: rtl/fpa_arbiter.sv
// -----------------------------------------------------------------------------
// fpa_arbiter
//   Shares one external combinational single-precision FPA between NUM_REQ
//   requesters. Round-robin grant, registered operands held on the FPA for a
//   fixed settle window, and a registered result returned under a per-requester
//   valid/ready handshake.
//
//   Optional feature macro: FPA_ARB_STATS_EN (operation/exception counters).
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   req_valid/ready       per-requester request; ready is a one-hot accept pulse
//   req_a, req_b          packed operands, requester i at [i*W +: W]
//   fpa_a, fpa_b          operands to the FPA (held at last value when idle)
//   fpa_sum, fpa_flags    FPA result {Cout, overflow, underflow, exception}
//   rsp_valid/ready       one-hot result valid / per-requester accept
//   rsp_sum, rsp_flags    registered result shared by all requesters
//   rsp_id                index of the requester owning the current result
//   stat_ops, stat_exc    completed ops / ops with exception or overflow
// -----------------------------------------------------------------------------
module fpa_arbiter #(
    parameter int EXPONENT_LENGTH = 8,
    parameter int MANTISSA_LENGTH = 23,
    parameter int NUM_REQ         = 4,
    parameter int SETTLE_CYCLES   = 1,
    localparam int W  = EXPONENT_LENGTH + MANTISSA_LENGTH + 1,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*W-1:0] req_a,
    input  logic [NUM_REQ*W-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [W-1:0]         fpa_a,
    output logic [W-1:0]         fpa_b,
    input  logic [W-1:0]         fpa_sum,
    input  logic [3:0]           fpa_flags,
    output logic [NUM_REQ-1:0]   rsp_valid,
    input  logic [NUM_REQ-1:0]   rsp_ready,
    output logic [W-1:0]         rsp_sum,
    output logic [3:0]           rsp_flags,
    output logic [IW-1:0]        rsp_id,
    output logic [15:0]          stat_ops,
    output logic [15:0]          stat_exc
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t              r_state, w_state_nxt;
    logic [IW-1:0]       r_ptr, r_id;
    logic [W-1:0]        r_op_a, r_op_b, r_sum;
    logic [3:0]          r_flags;
    logic [CW-1:0]       r_cnt;

    logic                w_gnt_found;
    logic [IW-1:0]       w_gnt_id;
    int                  w_idx;
    logic [NUM_REQ-1:0]  w_gnt_oh, w_id_oh;
    logic                w_accept, w_capture, w_release;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        w_idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_gnt_found && req_valid[IW'(w_idx)]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = IW'(w_idx);
            end
        end
    end

    assign w_gnt_oh = NUM_REQ'(1) << w_gnt_id;
    assign w_id_oh  = NUM_REQ'(1) << r_id;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        rsp_valid   = '0;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_found) begin
                    // Gated by reset so req_ready reads 0 while reset is held.
                    req_ready   = w_gnt_oh & {NUM_REQ{rst_n}};
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == CW'(SETTLE_CYCLES - 1)) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = w_id_oh;
                // Only the owner's rsp_ready releases the result.
                if (rsp_ready[r_id]) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_id    <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_sum   <= '0;
            r_flags <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_accept) begin
                r_op_a <= req_a[w_gnt_id*W +: W];
                r_op_b <= req_b[w_gnt_id*W +: W];
                r_id   <= w_gnt_id;
                r_ptr  <= (w_gnt_id == IW'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
            end
            if (r_state == S_EXEC)
                r_cnt <= w_capture ? '0 : r_cnt + 1'b1;
            if (w_capture) begin
                r_sum   <= fpa_sum;
                r_flags <= fpa_flags;
            end
        end
    end

    assign fpa_a     = r_op_a;
    assign fpa_b     = r_op_b;
    assign rsp_sum   = r_sum;
    assign rsp_flags = r_flags;
    assign rsp_id    = r_id;

`ifdef FPA_ARB_STATS_EN
    logic [15:0] r_stat_ops, r_stat_exc;

    // Saturating counters, stepped on each completed handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_ops <= '0;
            r_stat_exc <= '0;
        end else if (w_release) begin
            if (r_stat_ops != 16'hFFFF)
                r_stat_ops <= r_stat_ops + 16'd1;
            if ((r_flags[0] || r_flags[2]) && r_stat_exc != 16'hFFFF)
                r_stat_exc <= r_stat_exc + 16'd1;
        end
    end

    assign stat_ops = r_stat_ops;
    assign stat_exc = r_stat_exc;
`else
    assign stat_ops = '0;
    assign stat_exc = '0;
`endif

endmodule

// File: tb/tb_fpa_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fpa_arbiter
//   Directed bench for fpa_arbiter. Two instances: u_dut (SETTLE_CYCLES=1) and
//   u_dut3 (SETTLE_CYCLES=3, used for the reset-mid-EXEC and latency vectors).
//   The FPA is a bench stand-in: a table of known single-precision sums, with
//   integer a+b as a deterministic fallback; flags come from the bench.
// -----------------------------------------------------------------------------
module tb_fpa_arbiter;

    logic         clk = 1'b0;
    logic         rst_n, rst3_n;

    logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [127:0] req_a, req_b;
    logic [31:0]  fpa_a, fpa_b, fpa_sum, rsp_sum;
    logic [3:0]   fpa_flags, rsp_flags, tb_flags;
    logic [1:0]   rsp_id;
    logic [15:0]  stat_ops, stat_exc;

    logic [3:0]   req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [127:0] req_a3, req_b3;
    logic [31:0]  fpa_a3, fpa_b3, fpa_sum3, rsp_sum3;
    logic [3:0]   fpa_flags3, rsp_flags3;
    logic [1:0]   rsp_id3;
    logic [15:0]  stat_ops3, stat_exc3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] fpa_model(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h40480000 && b == 32'h40480000) return 32'h40c80000;
        if (a == 32'h40a80000 && b == 32'hc0440000) return 32'h400c0000;
        if (a == 32'hc0a80000 && b == 32'hc0480000) return 32'hc1060000;
        return a + b;
    endfunction

    assign fpa_sum    = fpa_model(fpa_a, fpa_b);
    assign fpa_flags  = tb_flags;
    assign fpa_sum3   = fpa_model(fpa_a3, fpa_b3);
    assign fpa_flags3 = 4'b0000;

    fpa_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_sum(fpa_sum), .fpa_flags(fpa_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_flags(rsp_flags), .rsp_id(rsp_id),
        .stat_ops(stat_ops), .stat_exc(stat_exc)
    );

    fpa_arbiter #(.NUM_REQ(4), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n),
        .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3), .req_ready(req_ready3),
        .fpa_a(fpa_a3), .fpa_b(fpa_b3), .fpa_sum(fpa_sum3), .fpa_flags(fpa_flags3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_sum(rsp_sum3),
        .rsp_flags(rsp_flags3), .rsp_id(rsp_id3),
        .stat_ops(stat_ops3), .stat_exc(stat_exc3)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Waits (bounded) for a grant on u_dut, checks it, then steps past the
    // accept edge so the caller may change req_valid safely.
    task automatic wait_grant(input string tag, input int exp, output int cyc);
        cyc = 0;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (req_ready != 4'b0000) break;
            @(posedge clk); #3;
            cyc++;
        end
        chk(tag, 64'(req_ready), 64'(4'b0001 << exp));
        @(posedge clk); #1;
    endtask

    // One complete operation on u_dut with rsp_ready held high.
    task automatic run_op(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input logic [3:0] fl);
        int c;
        tb_flags = fl;
        req_a[idx*32 +: 32] = a;
        req_b[idx*32 +: 32] = b;
        req_valid = 4'b0001 << idx;
        wait_grant({tag, "_gnt"}, idx, c);
        req_valid = 4'b0000;
        chk({tag, "_exec_vld"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_fpa_a"}, 64'(fpa_a), 64'(a));
        chk({tag, "_fpa_b"}, 64'(fpa_b), 64'(b));
        @(posedge clk); #1;
        chk({tag, "_vld"},   64'(rsp_valid), 64'(4'b0001 << idx));
        chk({tag, "_sum"},   64'(rsp_sum),   64'(exp));
        chk({tag, "_flags"}, 64'(rsp_flags), 64'(fl));
        chk({tag, "_id"},    64'(rsp_id),    64'(idx));
        @(posedge clk); #1;
        chk({tag, "_done"},  64'(rsp_valid), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int exp_ops, exp_exc;
        logic [3:0] seen;

        rst_n = 1'b0; rst3_n = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0; tb_flags = '0;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0; rsp_ready3 = '0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_fpa_a",     64'(fpa_a),     64'(0));
        chk("rst_fpa_b",     64'(fpa_b),     64'(0));
        chk("rst_rsp_sum",   64'(rsp_sum),   64'(0));
        chk("rst_rsp_flags", 64'(rsp_flags), 64'(0));
        chk("rst_rsp_id",    64'(rsp_id),    64'(0));
        chk("rst_stat_ops",  64'(stat_ops),  64'(0));
        chk("rst_stat_exc",  64'(stat_exc),  64'(0));
        rst_n = 1'b1; rst3_n = 1'b1;
        @(posedge clk); #2;

        // Single op and mixed-sign ops.
        rsp_ready = 4'b1111;
        run_op("single", 0, 32'h40480000, 32'h40480000, 32'h40c80000, 4'b0000);
        run_op("mix1",   2, 32'h40a80000, 32'hc0440000, 32'h400c0000, 4'b0000);
        run_op("mix2",   2, 32'hc0a80000, 32'hc0480000, 32'hc1060000, 4'b0100);

        // Round-robin from reset.
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = 32'(i + 1);
            req_b[i*32 +: 32] = 32'h100;
        end
        req_valid = 4'b1111;
        wait_grant("rr0", 0, c);
        wait_grant("rr1", 1, c);
        wait_grant("rr2", 2, c);
        wait_grant("rr3", 3, c);
        wait_grant("rr4", 0, c);
        req_valid = 4'b1010;
        wait_grant("rr5", 1, c);
        wait_grant("rr6", 3, c);
        wait_grant("rr7", 1, c);
        wait_grant("rr8", 3, c);
        req_valid = 4'b0000;
        @(posedge clk); #1;
        chk("rr8_sum", 64'(rsp_sum), 64'(32'h104));
        @(posedge clk); #2;

        // Back-pressure: ptr is 0 after the last grant to 3.
        rsp_ready = 4'b0000;
        req_a[31:0] = 32'h3f800000; req_b[31:0] = 32'h3f800000;
        req_a[63:32] = 32'h10; req_b[63:32] = 32'h20;
        req_valid = 4'b0001;
        wait_grant("bp_gnt0", 0, c);
        req_valid = 4'b0010;
        chk("bp_exec_rdy", 64'(req_ready), 64'(0));
        @(posedge clk); #1;
        rsp_ready = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            chk("bp_vld", 64'(rsp_valid), 64'(4'b0001));
            chk("bp_sum", 64'(rsp_sum),   64'(32'h7f000000));
            chk("bp_id",  64'(rsp_id),    64'(0));
            chk("bp_rdy", 64'(req_ready), 64'(0));
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        rsp_ready = 4'b0001;
        wait_grant("bp_rel_gnt", 1, c);
        chk("bp_rel_cyc", 64'(c), 64'(1));
        req_valid = 4'b0000;
        rsp_ready = 4'b1111;
        @(posedge clk); #1;
        chk("bp_r1_sum", 64'(rsp_sum), 64'(32'h30));
        chk("bp_r1_id",  64'(rsp_id),  64'(1));
        @(posedge clk); #2;

        // Reset mid-EXEC on the SETTLE_CYCLES=3 instance.
        rsp_ready3 = 4'b1111;
        req_a3[95:64] = 32'h40480000; req_b3[95:64] = 32'h40480000;
        req_valid3 = 4'b0100;
        #1;
        chk("r3_gnt2", 64'(req_ready3), 64'(4'b0100));
        @(posedge clk); #1;
        req_valid3 = 4'b0000;
        @(posedge clk); #2;
        chk("r3_exec_fpa_a", 64'(fpa_a3), 64'(32'h40480000));
        rst3_n = 1'b0;
        req_valid3 = 4'b1111;
        #1;
        chk("r3_rst_vld",   64'(rsp_valid3), 64'(0));
        chk("r3_rst_fpa_a", 64'(fpa_a3),     64'(0));
        chk("r3_rst_id",    64'(rsp_id3),    64'(0));
        chk("r3_rst_sum",   64'(rsp_sum3),   64'(0));
        chk("r3_rst_rdy",   64'(req_ready3), 64'(0));
        req_valid3 = 4'b0000;
        @(posedge clk); #5;
        rst3_n = 1'b1;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid3;
        end
        chk("r3_no_rsp", 64'(seen), 64'(0));
        req_a3[63:32] = 32'hc0a80000; req_b3[63:32] = 32'hc0480000;
        req_valid3 = 4'b1010;
        #1;
        chk("r3_ptr0_gnt", 64'(req_ready3), 64'(4'b0010));
        @(posedge clk); #1;
        req_valid3 = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            chk("r3_lat_wait", 64'(rsp_valid3), 64'(0));
            @(posedge clk); #1;
        end
        chk("r3_lat_vld", 64'(rsp_valid3), 64'(4'b0010));
        chk("r3_lat_sum", 64'(rsp_sum3),   64'(32'hc1060000));
        @(posedge clk); #2;

        // Statistics from a fresh reset.
        rst_n = 1'b0;
        #1;
        chk("st_rst_ops", 64'(stat_ops), 64'(0));
        chk("st_rst_exc", 64'(stat_exc), 64'(0));
        @(posedge clk); #2;
        rst_n = 1'b1;
        run_op("st1", 0, 32'h40480000, 32'h40480000, 32'h40c80000, 4'b0000);
        run_op("st2", 0, 32'h1, 32'h2, 32'h3, 4'b1010);
        run_op("st3", 0, 32'h5, 32'h6, 32'hb, 4'b0000);
        run_op("st4", 0, 32'h7, 32'h8, 32'hf, 4'b0001);
`ifdef FPA_ARB_STATS_EN
        exp_ops = 4; exp_exc = 1;
`else
        exp_ops = 0; exp_exc = 0;
`endif
        chk("st_ops", 64'(stat_ops), 64'(exp_ops));
        chk("st_exc", 64'(stat_exc), 64'(exp_exc));

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
